// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter
// Shares one single-port asynchronous SRAM between a write requester (record
// path) and a read requester (playback path). Round-robin arbitration and
// fixed-length WE_N / OE_N strobes. A write completes with a one-cycle ack.
// A read completes with a one-cycle valid, and o_rd_data holds the captured word.
//
// Handshake: each requester holds its req (and addr/data) level-high until it
// sees its 1-cycle ack/valid pulse, and drops req on that same clock edge.
// A req raised while an access is in flight waits for the next S_IDLE.
// An access that has been granted always completes, even if its req drops.
module sram_access_arbiter #(
   parameter int ADDR_W    = 20,
   parameter int DATA_W    = 16,
   parameter int WR_CYCLES = 2,
   parameter int RD_CYCLES = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_wr_req,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ack,
   input  logic              i_rd_req,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_busy,
   output logic [ADDR_W-1:0] o_SRAM_ADDR,
   inout  wire  [DATA_W-1:0] io_SRAM_DQ,
   output logic              o_SRAM_WE_N,
   output logic              o_SRAM_OE_N,
   output logic              o_SRAM_CE_N,
   output logic              o_SRAM_LB_N,
   output logic              o_SRAM_UB_N
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR      = 3'd1;
   localparam logic [2:0] S_WR_HOLD = 3'd2;
   localparam logic [2:0] S_RD      = 3'd3;
   localparam logic [2:0] S_RD_DONE = 3'd4;

   localparam int MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_wr_q, last_wr_d;   // 1: last grant was the writer
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              grant_wr, grant_rd;
   logic              dq_oe;

   // Next-state logic: arbitration in S_IDLE, then fixed-length strobe phases.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_wr_d = last_wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rd_data_d = rd_data_q;
      grant_wr  = 1'b0;
      grant_rd  = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d    = '0;
            // On a tie, the requester opposite the last grant wins.
            grant_wr = i_wr_req && (!i_rd_req || !last_wr_q);
            grant_rd = i_rd_req && (!i_wr_req || last_wr_q);
            if (grant_wr) begin
               state_d   = S_WR;
               addr_d    = i_wr_addr;
               wdata_d   = i_wr_data;
               last_wr_d = 1'b1;
            end else if (grant_rd) begin
               state_d   = S_RD;
               addr_d    = i_rd_addr;
               last_wr_d = 1'b0;
            end
         end
         S_WR: begin
            if (cnt_q == WR_LAST) begin
               state_d = S_WR_HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WR_HOLD: state_d = S_IDLE;
         S_RD: begin
            if (cnt_q == RD_LAST) begin
               state_d   = S_RD_DONE;
               cnt_d     = '0;
               rd_data_d = io_SRAM_DQ;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RD_DONE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Control state; reset releases the strobes and the bus immediately.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         last_wr_q <= 1'b0;
         addr_q    <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_wr_q <= last_wr_d;
         addr_q    <= addr_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Write data register; only visible on the pins while a write is active.
   always_ff @(posedge i_clk) begin
      wdata_q <= wdata_d;
   end

   // Strobes and pulses decode straight from the state register.
   assign dq_oe       = (state_q == S_WR) || (state_q == S_WR_HOLD);
   assign io_SRAM_DQ  = dq_oe ? wdata_q : {DATA_W{1'bz}};
   assign o_SRAM_ADDR = addr_q;
   assign o_SRAM_WE_N = (state_q != S_WR);
   assign o_SRAM_OE_N = (state_q != S_RD);
   assign o_SRAM_CE_N = 1'b0;
   assign o_SRAM_LB_N = 1'b0;
   assign o_SRAM_UB_N = 1'b0;
   assign o_wr_ack    = (state_q == S_WR_HOLD);
   assign o_rd_valid  = (state_q == S_RD_DONE);
   assign o_rd_data   = rd_data_q;
   assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Testbench for sram_access_arbiter with a behavioural asynchronous SRAM on the
// pins and a bus probe that can drive the data bus to show it is released.
module tb_sram_access_arbiter;

  logic        clk;
  logic        rst_n;
  logic        wr_req, rd_req;
  logic [19:0] wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        wr_ack, rd_valid, busy;
  logic [15:0] rd_data;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_lb_n, sram_ub_n;
  logic        probe_en;
  logic [15:0] probe_val;
  logic [15:0] mem [0:255];

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_access_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_valid(rd_valid), .o_rd_data(rd_data),
    .o_busy(busy), .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(sram_dq),
    .o_SRAM_WE_N(sram_we_n), .o_SRAM_OE_N(sram_oe_n), .o_SRAM_CE_N(sram_ce_n),
    .o_SRAM_LB_N(sram_lb_n), .o_SRAM_UB_N(sram_ub_n)
  );

  // ---------------- SRAM model ----------------
  initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  always @(posedge sram_we_n) mem[sram_addr[7:0]] <= sram_dq;
  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;
  assign sram_dq = probe_en ? probe_val : 16'hzzzz;

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) begin
      n_errors++; $display("FAIL reset_strobes we_n=%b oe_n=%b want 1 1", sram_we_n, sram_oe_n);
    end
    n_checks++;
    if (sram_addr !== 20'h0 || rd_data !== 16'h0) begin
      n_errors++; $display("FAIL reset_regs addr=%h rd_data=%h want 0 0", sram_addr, rd_data);
    end
    n_checks++;
    if (busy !== 1'b0 || wr_ack !== 1'b0 || rd_valid !== 1'b0) begin
      n_errors++; $display("FAIL reset_flags busy=%b ack=%b valid=%b want 0 0 0", busy, wr_ack, rd_valid);
    end
    n_checks++;
    if (sram_ce_n !== 1'b0 || sram_lb_n !== 1'b0 || sram_ub_n !== 1'b0) begin
      n_errors++; $display("FAIL reset_ties ce=%b lb=%b ub=%b want 0 0 0", sram_ce_n, sram_lb_n, sram_ub_n);
    end
    probe_val = 16'hA5A5; probe_en = 1'b1; #1;
    n_checks++;
    if (sram_dq !== 16'hA5A5) begin
      n_errors++; $display("FAIL reset_dq_float dq=%h want probe a5a5", sram_dq);
    end
    probe_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write;
    logic exp_we, exp_ack, exp_busy;
    wr_addr = 20'h00010; wr_data = 16'hBEEF; wr_req = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      exp_we = (j >= 3); exp_ack = (j == 3); exp_busy = (j <= 3);
      n_checks++;
      if (sram_we_n !== exp_we || wr_ack !== exp_ack || busy !== exp_busy || sram_oe_n !== 1'b1) begin
        n_errors++;
        $display("FAIL write_cycle%0d we_n=%b ack=%b busy=%b oe_n=%b want %b %b %b 1",
                 j, sram_we_n, wr_ack, busy, sram_oe_n, exp_we, exp_ack, exp_busy);
      end
      if (j <= 3) begin
        n_checks++;
        if (sram_addr !== 20'h00010 || sram_dq !== 16'hBEEF) begin
          n_errors++; $display("FAIL write_bus%0d addr=%h dq=%h want 00010 beef", j, sram_addr, sram_dq);
        end
      end
      if (j == 3) wr_req = 1'b0;
    end
    n_checks++;
    if (mem[8'h10] !== 16'hBEEF) begin
      n_errors++; $display("FAIL write_mem mem=%h want beef", mem[8'h10]);
    end
  endtask

  task automatic test_read;
    logic exp_oe, exp_valid;
    logic [15:0] exp_data;
    rd_addr = 20'h00010; rd_req = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      exp_oe = (j >= 3); exp_valid = (j == 3);
      exp_data = (j >= 3) ? 16'hBEEF : 16'h0000;
      n_checks++;
      if (sram_oe_n !== exp_oe || rd_valid !== exp_valid || rd_data !== exp_data ||
          sram_we_n !== 1'b1 || busy !== (j <= 3)) begin
        n_errors++;
        $display("FAIL read_cycle%0d oe_n=%b valid=%b data=%h we_n=%b busy=%b want %b %b %h 1 %b",
                 j, sram_oe_n, rd_valid, rd_data, sram_we_n, busy, exp_oe, exp_valid, exp_data, (j <= 3));
      end
      if (j == 3) rd_req = 1'b0;
    end
  endtask

  task automatic test_max_addr;
    wr_addr = 20'hFFFFF; wr_data = 16'h5A5A; wr_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sram_addr !== 20'hFFFFF || sram_we_n !== 1'b0) begin
      n_errors++; $display("FAIL max_addr addr=%h we_n=%b want fffff 0", sram_addr, sram_we_n);
    end
    repeat (2) @(negedge clk);
    wr_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem[8'hFF] !== 16'h5A5A) begin
      n_errors++; $display("FAIL max_addr_mem mem=%h want 5a5a", mem[8'hFF]);
    end
  endtask

  task automatic test_reset_mid_write;
    int acks;
    wr_addr = 20'h00040; wr_data = 16'h1234; wr_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sram_we_n !== 1'b0) begin
      n_errors++; $display("FAIL midrst_pre we_n=%b want 0", sram_we_n);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || busy !== 1'b0 || wr_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_async we_n=%b oe_n=%b busy=%b ack=%b want 1 1 0 0", sram_we_n, sram_oe_n, busy, wr_ack);
    end
    probe_val = 16'hA5A5; probe_en = 1'b1; #1;
    n_checks++;
    if (sram_dq !== 16'hA5A5) begin
      n_errors++; $display("FAIL midrst_dq_float dq=%h want probe a5a5", sram_dq);
    end
    probe_en = 1'b0;
    wr_req = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (wr_ack || busy) acks++;
    end
    n_checks++;
    if (acks != 0) begin
      n_errors++; $display("FAIL midrst_no_ack active_cycles=%0d want 0", acks);
    end
  endtask

  task automatic test_back_to_back;
    int nwr, nrd, comp, j;
    logic exp_is_wr;
    logic [15:0] exp_d;
    nwr = 0; nrd = 0; comp = 0; j = 0;
    wr_addr = 20'h00020; wr_data = 16'h1000; rd_addr = 20'h00020;
    wr_req = 1'b1; rd_req = 1'b1;
    while (comp < 8 && j < 60) begin
      @(negedge clk); j++;
      if ((wr_ack && rd_valid) || (!busy && (wr_ack || rd_valid))) begin
        n_checks++; n_errors++;
        $display("FAIL b2b_pulse_excl cycle=%0d ack=%b valid=%b busy=%b", j, wr_ack, rd_valid, busy);
      end
      if (wr_ack || rd_valid) begin
        exp_is_wr = (comp % 2 == 0);
        n_checks++;
        if (wr_ack !== exp_is_wr || j != 3 + 4 * comp) begin
          n_errors++;
          $display("FAIL b2b_order n=%0d got_write=%b cycle=%0d want_write=%b cycle=%0d",
                   comp, wr_ack, j, exp_is_wr, 3 + 4 * comp);
        end
        if (wr_ack) begin
          exp_q.push_back(wr_data);
          nwr++;
          if (nwr == 4) wr_req = 1'b0;
          else begin
            wr_addr = 20'h00020 + 20'(nwr); wr_data = 16'h1000 + 16'(nwr);
          end
        end else begin
          exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
          n_checks++;
          if (rd_data !== exp_d) begin
            n_errors++; $display("FAIL b2b_rd_data n=%0d got=%h want=%h", nrd, rd_data, exp_d);
          end
          nrd++;
          if (nrd == 4) rd_req = 1'b0;
          else rd_addr = 20'h00020 + 20'(nrd);
        end
        comp++;
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    n_checks++;
    if (comp != 8) begin
      n_errors++; $display("FAIL b2b_timeout completions=%0d want 8", comp);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_drop;
    int pulses;
    pulses = 0;
    rd_addr = 20'h00020; rd_req = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j == 1) begin
        n_checks++;
        if (sram_oe_n !== 1'b0) begin
          n_errors++; $display("FAIL drop_oe_start oe_n=%b want 0", sram_oe_n);
        end
        rd_req = 1'b0;
      end
      if (rd_valid) pulses++;
      if (j == 3) begin
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'h1000) begin
          n_errors++; $display("FAIL drop_complete valid=%b data=%h want 1 1000", rd_valid, rd_data);
        end
      end
    end
    n_checks++;
    if (pulses != 1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL drop_pulse_count pulses=%0d busy=%b want 1 0", pulses, busy);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    probe_en = 1'b0; probe_val = '0;
    test_reset();
    test_write();
    test_read();
    test_max_addr();
    test_reset_mid_write();
    test_back_to_back();
    test_read_drop();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
